// File: rtl/sha256_job_arbiter.sv
// Round-robin job scheduler sharing one simplified_sha256 core among NUM_REQ
// requesters. Launches the core with a one-cycle start pulse, follows its
// level-type done through the busy period, and returns ack (success) or err
// (watchdog expiry) to the owning requester.
module sha256_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*16-1:0]   req_msg_addr,
    input  logic [NUM_REQ*16-1:0]   req_out_addr,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      err,
    output logic                    core_start,
    output logic [15:0]             core_message_addr,
    output logic [15:0]             core_output_addr,
    input  logic                    core_done,
    output logic                    busy,
    output logic [15:0]             job_count
);

    localparam int PW = $clog2(NUM_REQ);
    // One extra value of headroom: the counter may step to TIMEOUT_CYCLES when
    // WAIT_BUSY exits on its last allowed cycle.
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

    state_t                      state;
    logic [PW-1:0]               ptr;
    logic [PW-1:0]               owner;
    logic [PW-1:0]               win_idx;
    logic                        win_found;
    logic [WW-1:0]               wd;
    logic                        ok;
    logic [NUM_REQ-1:0][15:0]    msg_v;
    logic [NUM_REQ-1:0][15:0]    out_v;

    assign msg_v = req_msg_addr;
    assign out_v = req_out_addr;

    // Round-robin search: first asserted req starting at ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[(int'(ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    // Job FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            owner             <= '0;
            wd                <= '0;
            ok                <= 1'b0;
            grant             <= '0;
            ack               <= '0;
            err               <= '0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            busy              <= 1'b0;
            job_count         <= '0;
        end else begin
            ack        <= '0;
            err        <= '0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    // A core still finishing a timed-out job blocks new grants.
                    if (win_found && core_done) begin
                        owner             <= win_idx;
                        grant             <= NUM_REQ'(1) << win_idx;
                        core_message_addr <= msg_v[win_idx];
                        core_output_addr  <= out_v[win_idx];
                        busy              <= 1'b1;
                        state             <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    core_start <= 1'b1;
                    wd         <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!core_done) begin
                        wd    <= wd + 1'b1;
                        state <= WAIT_DONE;
                    end else if (wd >= WD_LAST) begin
                        ok    <= 1'b0;
                        state <= RESPOND;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        ok    <= 1'b1;
                        state <= RESPOND;
                    end else if (wd >= WD_LAST) begin
                        ok    <= 1'b0;
                        state <= RESPOND;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESPOND: begin
                    // grant still holds the owner's one-hot bit here.
                    if (ok) begin
                        ack       <= grant;
                        job_count <= job_count + 16'd1;
                    end else begin
                        err <= grant;
                    end
                    grant <= '0;
                    ptr   <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
